// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters.
// Tracks the core's busy flag through start and completion, with a start watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int START_TO = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         p_data,
    output logic                      data_valid,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      active,
    output logic                      err_timeout
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(START_TO) + 1;
    localparam logic [ID_W:0]    N_EXT    = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ID_W-1:0]   next_ptr;
    logic [DATA_W-1:0] slot [N_REQ];
    logic [ID_W:0]     cand;
    logic [ID_W-1:0]   win;
    logic              found;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slot[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search upward from rr_ptr with explicit wrap so non-power-of-2 N_REQ works.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
    assign cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            p_data      <= '0;
            data_valid  <= 1'b0;
            ack         <= '0;
            done        <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ack         <= '0;
            done        <= '0;
            data_valid  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && found) begin
                        grant_id   <= win;
                        p_data     <= slot[win];
                        ack        <= N_REQ'(1) << win;
                        data_valid <= 1'b1;
                        active     <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        cnt <= cnt_next;
                        // Stuck core: give up on this frame and move the pointer past it.
                        if (cnt_next >= CNT_LAST) begin
                            err_timeout <= 1'b1;
                            rr_ptr      <= next_ptr;
                            active      <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done   <= N_REQ'(1) << grant_id;
                        rr_ptr <= next_ptr;
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares them against ack/done/err_timeout pulses.
module tb_uart_tx_arbiter;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 8;
    localparam int START_TO = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    enable = 1'b0;
    logic                    tx_busy = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       p_data;
    logic                    data_valid;
    logic [1:0]              grant_id;
    logic                    active;
    logic                    err_timeout;

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .START_TO(START_TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .req_data(req_data),
        .ack(ack), .done(done), .p_data(p_data), .data_valid(data_valid),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_ACK, EV_DONE, EV_TOUT} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   failed = 0;
    int   ack_count = 0;
    int   done_count = 0;
    int   tout_count = 0;
    int   fall_cyc = 0;
    int   last_ack_cyc = 0;
    bit   uart_on = 1'b1;
    int   busy_len = 10;
    int   busy_left = 0;
    bit   start_pending = 1'b0;

    task automatic check_output(string name, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] slot_of(logic [31:0] d, int i);
        return d[i*8 +: 8];
    endfunction

    task automatic expect_frame(int id, logic [7:0] data, bit timeout);
        exp_q.push_back('{EV_ACK, id, data});
        exp_q.push_back('{timeout ? EV_TOUT : EV_DONE, id, 8'h00});
    endtask

    task automatic apply_stimulus(logic en, logic [3:0] r, logic [31:0] d);
        @(negedge clk);
        enable   = en;
        req      = r;
        req_data = d;
    endtask

    task automatic wait_count(string name, ev_kind_t kind, int target, int budget);
        int n = 0;
        int cur = 0;
        while (n < budget) begin
            @(negedge clk);
            #1;
            cur = (kind == EV_ACK) ? ack_count : (kind == EV_DONE) ? done_count : tout_count;
            if (cur >= target) break;
            n++;
        end
        if (n >= budget) begin
            tests++;
            failed++;
            $display("[TB] FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    // UART core model: busy rises the cycle after the start pulse and lasts busy_len cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            busy_left     = 0;
            start_pending = 1'b0;
            tx_busy       = 1'b0;
        end else if (start_pending) begin
            start_pending = 1'b0;
            tx_busy       = 1'b1;
            busy_left     = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                tx_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end
        if (rst && uart_on && data_valid) start_pending = 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (ack != '0 || data_valid) begin
                ack_count++;
                last_ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++; failed++;
                    $display("[TB] FAIL unexpected ack: got 0x%0h, expected none", ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("ack order", 64'(int'(mon_e.kind)), 64'(int'(EV_ACK)));
                    check_output("ack onehot", 64'(ack), 64'(1) << mon_e.id);
                    check_output("data_valid", 64'(data_valid), 64'(1));
                    check_output("p_data", 64'(p_data), 64'(mon_e.data));
                    check_output("grant_id", 64'(grant_id), 64'(mon_e.id));
                    check_output("active in load", 64'(active), 64'(1));
                end
            end
            if (done != '0) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    tests++; failed++;
                    $display("[TB] FAIL unexpected done: got 0x%0h, expected none", done);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("done order", 64'(int'(mon_e.kind)), 64'(int'(EV_DONE)));
                    check_output("done onehot", 64'(done), 64'(1) << mon_e.id);
                    check_output("done latency", 64'(cyc), 64'(fall_cyc + 1));
                end
            end
            if (err_timeout) begin
                tout_count++;
                if (exp_q.size() == 0) begin
                    tests++; failed++;
                    $display("[TB] FAIL unexpected err_timeout: got 1, expected 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("timeout order", 64'(int'(mon_e.kind)), 64'(int'(EV_TOUT)));
                    check_output("timeout delay", 64'(cyc - last_ack_cyc), 64'(START_TO));
                    check_output("done at timeout", 64'(done), 64'(0));
                end
            end
        end
    end

    initial begin
        // Reset held with random inputs: every output must stay at its reset value.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req      = 4'($urandom);
            req_data = $urandom;
            enable   = 1'($urandom);
            tx_busy  = 1'($urandom);
            #1;
            check_output("outputs in reset",
                         64'({ack, done, p_data, data_valid, grant_id, active, err_timeout}), 64'(0));
        end
        @(negedge clk);
        enable = 1'b0; req = '0; tx_busy = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_output("active after reset", 64'(active), 64'(0));
        check_output("data_valid after reset", 64'(data_valid), 64'(0));

        // Single request with a full-length frame.
        busy_len = 52080;
        expect_frame(2, 8'hA5, 1'b0);
        apply_stimulus(1'b1, 4'b0100, 32'h11A52233);
        wait_count("single ack", EV_ACK, 1, 20);
        apply_stimulus(1'b1, 4'b0000, 32'h11A52233);
        wait_count("single done", EV_DONE, 1, 52200);

        // Fresh reset so the round-robin pointer starts at 0.
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        busy_len = 10;
        for (int i = 0; i < 8; i++) expect_frame(i % 4, slot_of(32'h44332211, i % 4), 1'b0);
        apply_stimulus(1'b1, 4'b1111, 32'h44332211);
        wait_count("fairness acks", EV_ACK, 9, 400);
        apply_stimulus(1'b1, 4'b0000, 32'h44332211);
        wait_count("fairness dones", EV_DONE, 9, 60);

        // Enable gating, then enable dropped mid-frame.
        apply_stimulus(1'b0, 4'b0001, 32'hDEADBEEF);
        repeat (100) @(negedge clk);
        check_output("gated ack count", 64'(ack_count), 64'(9));
        check_output("gated active", 64'(active), 64'(0));
        busy_len = 30;
        expect_frame(0, 8'hEF, 1'b0);
        apply_stimulus(1'b1, 4'b0001, 32'hDEADBEEF);
        wait_count("enable ack", EV_ACK, 10, 20);
        apply_stimulus(1'b0, 4'b0001, 32'hDEADBEEF);
        wait_count("enable-drop done", EV_DONE, 10, 60);
        repeat (50) @(negedge clk);
        check_output("no load after enable drop", 64'(ack_count), 64'(10));
        check_output("idle after enable drop", 64'(active), 64'(0));

        // Watchdog: the core never starts; the next grant moves past the stalled requester.
        uart_on = 1'b0;
        expect_frame(1, 8'h22, 1'b1);
        apply_stimulus(1'b1, 4'b0010, 32'h44332211);
        wait_count("watchdog ack", EV_ACK, 11, 20);
        apply_stimulus(1'b1, 4'b0000, 32'h44332211);
        wait_count("watchdog timeout", EV_TOUT, 1, 40);
        check_output("no done on timeout", 64'(done_count), 64'(10));
        uart_on  = 1'b1;
        busy_len = 10;
        expect_frame(2, 8'h33, 1'b0);
        apply_stimulus(1'b1, 4'b0110, 32'h44332211);
        wait_count("post-timeout ack", EV_ACK, 12, 20);
        apply_stimulus(1'b1, 4'b0000, 32'h44332211);
        wait_count("post-timeout done", EV_DONE, 11, 60);

        // Reset in the middle of WAIT_DONE.
        busy_len = 200;
        exp_q.push_back('{EV_ACK, 3, 8'h44});
        apply_stimulus(1'b1, 4'b1000, 32'h44332211);
        wait_count("mid-frame ack", EV_ACK, 13, 20);
        apply_stimulus(1'b1, 4'b0000, 32'h44332211);
        repeat (5) @(negedge clk);
        check_output("active before reset", 64'(active), 64'(1));
        rst = 1'b0;
        @(negedge clk);
        check_output("outputs after mid-frame reset",
                     64'({ack, done, p_data, data_valid, grant_id, active, err_timeout}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_output("no done after reset", 64'(done_count), 64'(11));
        busy_len = 10;
        expect_frame(0, 8'h11, 1'b0);
        apply_stimulus(1'b1, 4'b0001, 32'h44332211);
        wait_count("fresh ack", EV_ACK, 14, 20);
        apply_stimulus(1'b1, 4'b0000, 32'h44332211);
        wait_count("fresh done", EV_DONE, 12, 60);

        repeat (5) @(negedge clk);
        check_output("scoreboard drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
